// File: rtl/idex_skid_stage_pkg.sv
// Shared pipeline package (aurora_pipe_pkg): default widths and the ID/EX beat layout.
// Modules re-declare the same field order at their own parameter widths, so the
// default-width beat_t below and a stage's local beat type are bit-compatible.
package aurora_pipe_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int REG_AW_DEF = 5;

    // ID/EX beat at default widths; field order is the packing order everywhere.
    typedef struct packed {
        logic                  wreg_en;
        logic                  wmem_en;
        logic [DATA_W_DEF-1:0] r1;
        logic [DATA_W_DEF-1:0] r2;
        logic [REG_AW_DEF-1:0] wreg;
    } beat_t;

endpackage

// File: rtl/idex_skid_stage_if.sv
// Upstream/downstream handshake bundle of the ID/EX skid stage.
// master = producer/consumer side (testbench or neighbouring stages), slave = the stage.
interface idex_skid_stage_if
    import aurora_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic              in_wreg_en;
    logic              in_wmem_en;
    logic [DATA_W-1:0] in_r1;
    logic [DATA_W-1:0] in_r2;
    logic [REG_AW-1:0] in_wreg;
    logic              out_valid;
    logic              out_ready;
    logic              out_wreg_en;
    logic              out_wmem_en;
    logic [DATA_W-1:0] out_r1;
    logic [DATA_W-1:0] out_r2;
    logic [REG_AW-1:0] out_wreg;

    modport master (
        output in_valid, in_wreg_en, in_wmem_en, in_r1, in_r2, in_wreg, out_ready,
        input  in_ready, out_valid, out_wreg_en, out_wmem_en, out_r1, out_r2, out_wreg
    );

    modport slave (
        input  in_valid, in_wreg_en, in_wmem_en, in_r1, in_r2, in_wreg, out_ready,
        output in_ready, out_valid, out_wreg_en, out_wmem_en, out_r1, out_r2, out_wreg
    );
endinterface

// File: rtl/idex_beat_reg.sv
// One valid bit plus beat payload. Priority: RST > clear > load > hold.
// Reset also zeroes the payload so the stage outputs read 0 out of reset.
module idex_beat_reg #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_beat,
    output logic         o_valid,
    output logic [W-1:0] o_beat
);
    logic         r_valid;
    logic [W-1:0] r_beat;

    // Valid/payload register with synchronous reset, clear and load.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid <= 1'b0;
            r_beat  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
            r_beat  <= r_beat;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_beat  <= i_beat;
        end else begin
            r_valid <= r_valid;
            r_beat  <= r_beat;
        end
    end

    assign o_valid = r_valid;
    assign o_beat  = r_beat;
endmodule

// File: rtl/idex_skid_stage.sv
// ID/EX pipeline register with a one-entry skid buffer (OR + SR).
// in_ready depends only on SR occupancy, so there is no combinational path from
// out_ready back upstream. Optional macro IDEX_PERF_CNT_EN enables the
// stall/bubble performance counters; otherwise those ports are tied to 0.
module idex_skid_stage
    import aurora_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               flush,
    idex_skid_stage_if.slave   bus,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);
    // Same field order as aurora_pipe_pkg::beat_t, at this instance's widths.
    typedef struct packed {
        logic              wreg_en;
        logic              wmem_en;
        logic [DATA_W-1:0] r1;
        logic [DATA_W-1:0] r2;
        logic [REG_AW-1:0] wreg;
    } stage_beat_t;

    localparam int BW = $bits(stage_beat_t);

    stage_beat_t w_in_beat;
    stage_beat_t w_or_beat;
    stage_beat_t w_sr_beat;
    stage_beat_t w_or_din;
    logic        w_or_valid;
    logic        w_sr_valid;
    logic        w_accept;
    logic        w_drain;
    logic        w_or_load;
    logic        w_or_clr;
    logic        w_sr_load;
    logic        w_sr_clr;

    assign w_in_beat = '{wreg_en: bus.in_wreg_en, wmem_en: bus.in_wmem_en,
                         r1: bus.in_r1, r2: bus.in_r2, wreg: bus.in_wreg};

    assign bus.in_ready = ~w_sr_valid;
    assign w_accept     = bus.in_valid & ~w_sr_valid;
    assign w_drain      = w_or_valid & bus.out_ready;

    // Load/clear steering for OR and SR; flush clears both and suppresses loads.
    always_comb begin
        w_or_load = 1'b0;
        w_or_clr  = 1'b0;
        w_sr_load = 1'b0;
        w_sr_clr  = 1'b0;
        w_or_din  = w_in_beat;
        if (flush) begin
            w_or_clr = 1'b1;
            w_sr_clr = 1'b1;
        end else if (w_drain) begin
            if (w_sr_valid) begin
                // SR full means in_ready=0, so no beat can arrive this cycle.
                w_or_load = 1'b1;
                w_or_din  = w_sr_beat;
                w_sr_clr  = 1'b1;
            end else if (w_accept) begin
                w_or_load = 1'b1;
            end else begin
                w_or_clr = 1'b1;
            end
        end else if (w_accept) begin
            if (w_or_valid) begin
                w_sr_load = 1'b1;
            end else begin
                w_or_load = 1'b1;
            end
        end else begin
            w_or_load = 1'b0;
        end
    end

    idex_beat_reg #(.W(BW)) u_or (
        .CLK     (CLK),
        .RST     (RST),
        .i_clr   (w_or_clr),
        .i_load  (w_or_load),
        .i_beat  (w_or_din),
        .o_valid (w_or_valid),
        .o_beat  (w_or_beat)
    );

    idex_beat_reg #(.W(BW)) u_sr (
        .CLK     (CLK),
        .RST     (RST),
        .i_clr   (w_sr_clr),
        .i_load  (w_sr_load),
        .i_beat  (w_in_beat),
        .o_valid (w_sr_valid),
        .o_beat  (w_sr_beat)
    );

    assign bus.out_valid   = w_or_valid;
    assign bus.out_wreg_en = w_or_valid & w_or_beat.wreg_en;
    assign bus.out_wmem_en = w_or_valid & w_or_beat.wmem_en;
    assign bus.out_r1      = w_or_beat.r1;
    assign bus.out_r2      = w_or_beat.r2;
    assign bus.out_wreg    = w_or_beat.wreg;

`ifdef IDEX_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Saturating stall/bubble counters; flush does not touch them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_or_valid && !bus.out_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (!w_or_valid && bus.out_ready && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
            end else begin
                r_bubble_cnt <= r_bubble_cnt;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_idex_skid_stage.sv
// Self-checking bench for idex_skid_stage: a directed vector table plus hand
// sequences, all checked against a queue-based scoreboard of held beats.
module tb_idex_skid_stage;
    import aurora_pipe_pkg::*;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          CLK;
    logic          RST;
    logic          flush;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;

    idex_skid_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

    idex_skid_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .flush      (flush),
        .bus        (bus),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic  rst;
        logic  flush;
        logic  iv;
        beat_t b;
        logic  ordy;
        logic  exp_ov;
        logic  exp_ir;
    } vec_t;

    int            ncheck = 0;
    int            nbad   = 0;
    beat_t         q[$];
    logic          model_ok = 1'b0;
    logic [CW-1:0] m_stall  = '0;
    logic [CW-1:0] m_bubble = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncheck++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic wen, input logic wm, input logic [63:0] r1,
                                 input logic [63:0] r2, input logic [4:0] wr);
        beat_t b;
        b.wreg_en = wen;
        b.wmem_en = wm;
        b.r1      = r1;
        b.r2      = r2;
        b.wreg    = wr;
        return b;
    endfunction

    // One clock: drive inputs, check held state against the model, update model at the edge.
    task automatic apply(input logic rst, input logic fl, input logic iv, input beat_t b,
                         input logic ordy, output logic accepted);
        int sz;
        RST             = rst;
        flush           = fl;
        bus.in_valid    = iv;
        bus.in_wreg_en  = b.wreg_en;
        bus.in_wmem_en  = b.wmem_en;
        bus.in_r1       = b.r1;
        bus.in_r2       = b.r2;
        bus.in_wreg     = b.wreg;
        bus.out_ready   = ordy;
        #1;
        sz = q.size();
        accepted = 1'b0;
        if (model_ok) begin
            chk("out_valid", {63'd0, bus.out_valid}, {63'd0, sz > 0});
            chk("in_ready", {63'd0, bus.in_ready}, {63'd0, sz < 2});
            if (sz > 0) begin
                chk("out_wreg_en", {63'd0, bus.out_wreg_en}, {63'd0, q[0].wreg_en});
                chk("out_wmem_en", {63'd0, bus.out_wmem_en}, {63'd0, q[0].wmem_en});
                chk("out_r1", bus.out_r1, q[0].r1);
                chk("out_r2", bus.out_r2, q[0].r2);
                chk("out_wreg", {59'd0, bus.out_wreg}, {59'd0, q[0].wreg});
            end else begin
                chk("idle_wreg_en", {63'd0, bus.out_wreg_en}, 64'd0);
                chk("idle_wmem_en", {63'd0, bus.out_wmem_en}, 64'd0);
            end
            chk("stall_cnt", {60'd0, stall_cnt}, {60'd0, m_stall});
            chk("bubble_cnt", {60'd0, bubble_cnt}, {60'd0, m_bubble});
        end
        if (rst) begin
            q.delete();
            m_stall  = '0;
            m_bubble = '0;
            model_ok = 1'b1;
        end else begin
`ifdef IDEX_PERF_CNT_EN
            if (sz > 0 && !ordy && m_stall != 4'hF) m_stall = m_stall + 4'd1;
            if (sz == 0 && ordy && m_bubble != 4'hF) m_bubble = m_bubble + 4'd1;
`endif
            if (fl) begin
                q.delete();
            end else begin
                if (sz > 0 && ordy) void'(q.pop_front());
                if (iv && sz < 2) begin
                    q.push_back(b);
                    accepted = 1'b1;
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    vec_t  tbl[13];
    beat_t nb;
    logic  acc;
    int    pushed;

    initial begin
        nb = mk(1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        // in_valid/fields/out_ready, then out_valid and in_ready expected after the edge
        tbl[0]  = '{1'b0, 1'b0, 1'b1, mk(1'b1, 1'b0, 64'h11, 64'h22, 5'd3), 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, nb, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, mk(1'b1, 1'b0, 64'hA1, 64'hA2, 5'd1), 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, mk(1'b0, 1'b1, 64'hB1, 64'hB2, 5'd2), 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, mk(1'b1, 1'b1, 64'hC1, 64'hC2, 5'd4), 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, nb, 1'b1, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, mk(1'b1, 1'b1, 64'hC1, 64'hC2, 5'd4), 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, nb, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, mk(1'b1, 1'b0, 64'hD1, 64'hD2, 5'd5), 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, mk(1'b1, 1'b1, 64'hE1, 64'hE2, 5'd6), 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, mk(1'b1, 1'b1, 64'hF1, 64'hF2, 5'd7), 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, mk(1'b0, 1'b1, 64'h55, 64'h66, 5'd9), 1'b1, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, nb, 1'b1, 1'b0, 1'b1};

        RST = 1'b1;
        flush = 1'b0;
        apply(1'b1, 1'b0, 1'b0, nb, 1'b0, acc);
        apply(1'b1, 1'b0, 1'b0, nb, 1'b0, acc);

        // Reset state
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_out_r1", bus.out_r1, 64'd0);
        chk("rst_out_wreg", {59'd0, bus.out_wreg}, 64'd0);
        chk("rst_stall", {60'd0, stall_cnt}, 64'd0);

        // Directed table: single beat, back-pressure A/B/C, flush, wmem-only beat
        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].b, tbl[i].ordy, acc);
            chk($sformatf("tbl%0d_out_valid", i), {63'd0, bus.out_valid}, {63'd0, tbl[i].exp_ov});
            chk($sformatf("tbl%0d_in_ready", i), {63'd0, bus.in_ready}, {63'd0, tbl[i].exp_ir});
        end
        chk("tbl0_accept_flags", {63'd0, tbl[10].exp_ov}, 64'd0);

        // Reset with both registers full and a beat offered
        apply(1'b0, 1'b0, 1'b1, mk(1'b1, 1'b0, 64'h71, 64'h72, 5'd1), 1'b0, acc);
        apply(1'b0, 1'b0, 1'b1, mk(1'b1, 1'b1, 64'h81, 64'h82, 5'd2), 1'b0, acc);
        chk("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
        apply(1'b1, 1'b1, 1'b1, mk(1'b1, 1'b1, 64'h91, 64'h92, 5'd3), 1'b1, acc);
        chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("midrst_out_r1", bus.out_r1, 64'd0);
        chk("midrst_wreg_en", {63'd0, bus.out_wreg_en}, 64'd0);

        // Counter saturation: one beat held, 20 stalled cycles
        apply(1'b0, 1'b0, 1'b1, mk(1'b1, 1'b0, 64'h1, 64'h2, 5'd1), 1'b0, acc);
        for (int i = 0; i < 20; i++) apply(1'b0, 1'b0, 1'b0, nb, 1'b0, acc);
`ifdef IDEX_PERF_CNT_EN
        chk("stall_sat", {60'd0, stall_cnt}, 64'd15);
`else
        chk("stall_tied", {60'd0, stall_cnt}, 64'd0);
`endif
        apply(1'b1, 1'b0, 1'b0, nb, 1'b0, acc);
        chk("stall_after_rst", {60'd0, stall_cnt}, 64'd0);
        chk("bubble_after_rst", {60'd0, bubble_cnt}, 64'd0);

        // 100 random beats with random back-pressure
        pushed = 0;
        for (int c = 0; c < 3000 && pushed < 100; c++) begin
            nb = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 31)));
            apply(1'b0, 1'b0, 1'($urandom_range(0, 1)), nb, 1'($urandom_range(0, 1)), acc);
            if (acc) pushed++;
        end
        chk("rand_beats_sent", 64'(pushed), 64'd100);
        nb = mk(1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        for (int c = 0; c < 10 && q.size() > 0; c++) apply(1'b0, 1'b0, 1'b0, nb, 1'b1, acc);
        apply(1'b0, 1'b0, 1'b0, nb, 1'b1, acc);
        chk("rand_drained", {63'd0, bus.out_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", ncheck, nbad);
        $finish;
    end
endmodule

// File: doc/idex_skid_stage.md
IDEX_SKID_STAGE -- requirements
Module: idex_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64, operand width.
REQ-002 SHALL have parameter REG_AW, default 5, destination-register address width.
REQ-003 SHALL have parameter CNT_W, default 32, performance-counter width.
REQ-004 SHALL have port CLK  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  in  1  discard all held and incoming beats.
REQ-007 SHALL have port in_valid  in  1  upstream beat present.
REQ-008 SHALL have port in_ready  out  1  stage accepts a beat this cycle.
REQ-009 SHALL have ports in_wreg_en, in_wmem_en  in  1 each  register-write and memory-write enables.
REQ-010 SHALL have ports in_r1, in_r2  in  DATA_W each  operands.
REQ-011 SHALL have port in_wreg  in  REG_AW  destination register.
REQ-012 SHALL have port out_valid  out  1  downstream beat present.
REQ-013 SHALL have port out_ready  in  1  downstream accepts.
REQ-014 SHALL have ports out_wreg_en, out_wmem_en, out_r1, out_r2, out_wreg  out  widths as inputs  held beat.
REQ-015 SHALL have ports stall_cnt, bubble_cnt  out  CNT_W each  performance counters.

Function
REQ-016 SHALL hold up to two beats: output register (OR) and skid register (SR), each with a valid bit.
REQ-017 SHALL drive in_ready = NOT SR.valid (registered state only; no combinational path from out_ready).
REQ-018 SHALL treat in_valid AND in_ready as accept and out_valid AND out_ready as drain.
REQ-019 SHALL load an accepted beat into OR when OR is empty or draining; otherwise into SR.
REQ-020 SHALL move SR into OR on drain when SR.valid, loading any simultaneously accepted beat into SR.
REQ-021 SHALL give 1-cycle latency in-to-out when OR is empty and sustain one beat/cycle with out_ready held high.
REQ-022 SHALL preserve beat order; no beat duplicated or dropped except by flush.
REQ-023 SHALL, on flush, clear OR.valid and SR.valid next edge and drop any beat accepted in the same cycle; flush overrides accept and drain.
REQ-024 SHALL force out_wreg_en and out_wmem_en to 0 whenever out_valid is 0; out_r1, out_r2 and out_wreg are don't-care then.
REQ-025 SHALL keep every out_* field stable while out_valid=1 and out_ready=0.
REQ-026 SHALL route each input field only to its same-named output (wreg_en to wreg_en, wmem_en to wmem_en).

Reset
REQ-027 SHALL, while RST=1, clear OR, SR and valid bits next edge: out_valid=0, all out_* data=0, in_ready=1, counters=0.
REQ-028 SHALL ignore in_valid in any cycle where RST=1; RST overrides flush.
REQ-029 SHALL, on RST mid-stream with both registers full, discard both beats.

Configuration
REQ-030 SHALL, with IDEX_PERF_CNT_EN defined, increment stall_cnt each cycle with out_valid=1 and out_ready=0, and bubble_cnt each cycle with out_valid=0 and out_ready=1, both saturating at all-ones, not cleared by flush.
REQ-031 SHALL, without IDEX_PERF_CNT_EN, keep the stall_cnt and bubble_cnt ports and tie them to 0 with no counter flops.

Structure
REQ-032 SHALL define in shared package aurora_pipe_pkg a parametrised beat struct (wreg_en, wmem_en, r1, r2, wreg) and constants DATA_W_DEF=64, REG_AW_DEF=5.
REQ-033 SHALL instantiate sub-module idex_beat_reg (one valid+beat register with load/clear) twice, for OR and SR.

Verification
REQ-034 SHALL cover: reset, then one beat r1=0x11, r2=0x22, wreg=3, wreg_en=1, out_ready=1 -> out_valid=1 one cycle later with the same fields.
REQ-035 SHALL cover: out_ready=0, three back-to-back beats A,B,C -> A in OR, B in SR, in_ready=0, C not accepted; out_ready=1 -> A,B,C drain in order.
REQ-036 SHALL cover: both registers full plus flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_wreg_en=0, out_wmem_en=0.
REQ-037 SHALL cover: beat with wreg_en=0, wmem_en=1 -> out_wreg_en=0, out_wmem_en=1.
REQ-038 SHALL cover, with IDEX_PERF_CNT_EN and CNT_W=4: 20 stalled cycles -> stall_cnt=15; RST -> 0.
REQ-039 SHALL cover: 100 random beats with random out_ready and no flush -> output sequence equals input sequence.
